// File: rtl/ksa_checker.sv
// Response monitor for the Kogge-Stone adder: recomputes {cout,sum} for every accepted
// operand set, compares it with the adder output after LATENCY cycles and keeps run statistics.
module ksa_checker #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      chk_count,
  output logic [15:0]      err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } vec_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]   state;
  logic [15:0]  remaining;
  logic         accept;
  logic [WIDTH:0] exp_p0;
  vec_t         vec_p0;
  vec_t         vec_cmp;
  logic         vld_cmp;
  logic         pending;
  logic         mismatch;
  logic [15:0]  err_next;

  // p0: accept and golden sum
  assign accept         = (state == RUN) && in_valid;
  assign exp_p0         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign vec_p0.exp_sum  = exp_p0[WIDTH-1:0];
  assign vec_p0.exp_cout = exp_p0[WIDTH];
  assign vec_p0.a        = a;
  assign vec_p0.b        = b;
  assign vec_p0.cin      = cin;

  generate
    if (LATENCY == 0) begin : g_comb
      assign vec_cmp = vec_p0;
      assign vld_cmp = accept;
      assign pending = 1'b0;
    end else begin : g_pipe
      vec_t              data_p [1:LATENCY];
      logic [LATENCY:1]  vld_p;

      // p1..pLATENCY: delay line; only the valid bits are reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p <= '0;
        end else begin
          vld_p[1] <= accept;
          for (int i = 2; i <= LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[1] <= vec_p0;
        for (int i = 2; i <= LATENCY; i++) data_p[i] <= data_p[i-1];
      end

      // Anything still short of the last stage means drain is not finished.
      always_comb begin
        pending = 1'b0;
        for (int i = 1; i < LATENCY; i++) pending = pending | vld_p[i];
      end

      assign vec_cmp = data_p[LATENCY];
      assign vld_cmp = vld_p[LATENCY];
    end
  endgenerate

  // compare stage
  assign mismatch = vld_cmp && ((dut_sum != vec_cmp.exp_sum) || (dut_cout != vec_cmp.exp_cout));
  assign err_next = mismatch ? sat_inc(err_count) : err_count;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      pass       <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_sum   <= '0;
      fail_cout  <= 1'b0;
    end else begin
      if (vld_cmp) chk_count <= sat_inc(chk_count);
      err_count <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= vec_cmp.a;
        fail_b     <= vec_cmp.b;
        fail_cin   <= vec_cmp.cin;
        fail_sum   <= dut_sum;
        fail_cout  <= dut_cout;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            chk_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_sum   <= '0;
            fail_cout  <= 1'b0;
            remaining  <= num_vectors;
            if (num_vectors == 16'd0) begin
              state <= DONE;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              if (LATENCY == 0) begin
                state <= DONE;
                pass  <= (err_next == 16'd0);
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        default: begin
          if (!pending) begin
            state <= DONE;
            pass  <= (err_next == 16'd0);
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ksa_checker.md
Name: ksa_checker

Overview:
Synthesizable self-checking response monitor for the 16-bit Kogge-Stone adder (ksa). It is the receiving end of the adder's stimulus interface: it samples each operand set driven into the adder, computes the golden {cout,sum}, and compares it against the adder outputs after a configurable pipeline latency. It counts checks and mismatches, captures the first failing vector, and reports pass/fail at the end of a run of a programmed length.

Parameters:
WIDTH, 16, operand/sum width.
LATENCY, 0, cycles from operand valid to DUT result valid (0 = combinational ksa); legal range 0..8.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a run (honoured in IDLE/DONE only).
num_vectors  input  16  vectors in the run, sampled on start.
in_valid  input  1  a/b/cin valid this cycle.
a  input  WIDTH  operand A as driven to DUT.
b  input  WIDTH  operand B as driven to DUT.
cin  input  1  carry-in as driven to DUT.
dut_sum  input  WIDTH  DUT sum.
dut_cout  input  1  DUT carry-out.
busy  output  1  high in RUN/DRAIN.
done  output  1  high in DONE.
pass  output  1  valid when done: err_count==0.
chk_count  output  16  comparisons performed, saturating at 16'hFFFF.
err_count  output  16  mismatches, saturating at 16'hFFFF.
fail_valid  output  1  first failure captured this run.
fail_a, fail_b  output  WIDTH  operands of first failure.
fail_cin  output  1  cin of first failure.
fail_sum  output  WIDTH  DUT sum of first failure.
fail_cout  output  1  DUT cout of first failure.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including pass, all counters, and all fail_* fields; expected-value pipeline valid bits cleared.
- Golden model: exp = a + b + cin computed at WIDTH+1 bits; exp_sum = exp[WIDTH-1:0], exp_cout = exp[WIDTH].
- Pipeline: {valid, exp_sum, exp_cout, a, b, cin} is delayed LATENCY stages. LATENCY=0: compare in the same cycle as the accepted in_valid.
- Comparison cycle: chk_count += 1. A mismatch is dut_sum!=exp_sum OR dut_cout!=exp_cout. On a mismatch, err_count += 1.
- First failure: if fail_valid==0 at a mismatch, latch the fail_* fields and set fail_valid. Later failures leave them unchanged.
- FSM states:
  - IDLE: start -> clear counters, fail_* and pass; load remaining=num_vectors. If num_vectors==0, go to DONE, otherwise go to RUN.
  - RUN: each in_valid is accepted and decrements remaining. The accept that takes remaining to 0 goes to DRAIN. in_valid is ignored at all other times.
  - DRAIN: wait until all pipeline valid bits are clear (exactly LATENCY cycles; 0 cycles when LATENCY=0, in which case go straight to DONE), then go to DONE.
  - DONE: done=1; pass=(err_count==0), registered on DONE entry. start -> same action as from IDLE.
- start asserted in RUN/DRAIN is ignored.
- in_valid gaps are allowed; the pipeline advances every cycle regardless of in_valid.
- Counter updates, the pipeline write and the final compare in the same cycle are all applied in that cycle.
- Run latency: done asserts in the cycle after the last comparison.
- rst mid-run aborts immediately to the reset state. No partial results are retained.

Test Plan:
1. LATENCY=0, num_vectors=3, correct adder. Vectors: 158A+7095+0, 52AF+9A4E+1, B903+C6BD+0 -> DUT gives 861F/0, ECFE/0, 7FC0/1; done=1, pass=1, chk_count=3, err_count=0, fail_valid=0.
2. Same vectors, with the third forced to dut_sum=7FC1 -> err_count=1, pass=0, fail_a=B903, fail_b=C6BD, fail_cin=0, fail_sum=7FC1, fail_cout=1.
3. Carry-only fault: FFFF+0001+0 with dut_sum=0000, dut_cout=0 -> mismatch counted (expected cout=1); fail_cout=0.
4. LATENCY=2 delayed DUT model, 4 vectors with in_valid gaps of 0..3 cycles -> zero errors. done asserts 3 cycles after the last in_valid (2 drain cycles plus 1).
5. num_vectors=0 with start -> done=1 and pass=1 the next cycle; chk_count=0.
6. Protocol corners:
   - start during RUN -> no effect.
   - rst pulse mid-run -> all outputs 0, state IDLE.
   - start from DONE -> counters and fail_* cleared, new run proceeds.
